// File: rtl/const_arbiter.sv
// const_arbiter
//   Round-robin arbiter sharing one constant ROM among NREQ requesters.
//   A grant in cycle T registers a one-hot ROM address (valid in T+1); the
//   ROM answers in T+2, when the response is presented tagged with the
//   requester id. At most one lookup is issued per cycle.
// Ports:
//   clk, reset     clock and synchronous active-high reset
//   req, sel       per-requester request level and 3-bit constant selector
//   gnt            one-hot combinational grant
//   rom_addr       registered one-hot ROM address (0 = no/invalid lookup)
//   rom_out        ROM data, rom_effective = ROM valid flag
//   rsp_valid/id   response strobe and requester id
//   rsp_data/err   constant value (0 when idle) and invalid-selector flag
module const_arbiter #(
  parameter int NREQ  = 4,
  parameter int IDW   = 2,
  parameter int WIDTH = 198,
  parameter int AW    = 7
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [3*NREQ-1:0]    sel,
  output logic [NREQ-1:0]      gnt,
  output logic [AW-1:0]        rom_addr,
  input  logic [WIDTH-1:0]     rom_out,
  input  logic                 rom_effective,
  output logic                 rsp_valid,
  output logic [IDW-1:0]       rsp_id,
  output logic [WIDTH-1:0]     rsp_data,
  output logic                 rsp_err
);

  logic [IDW-1:0] r_ptr;
  logic [AW-1:0]  r_rom_addr;
  logic           r_s1_valid;
  logic [IDW-1:0] r_s1_id;
  logic           r_s2_valid;
  logic [IDW-1:0] r_s2_id;

  logic [NREQ-1:0] w_gnt;
  logic            w_any;
  logic [IDW-1:0]  w_gnt_id;
  logic [IDW-1:0]  w_idx;
  logic [2:0]      w_sel;
  logic [AW-1:0]   w_addr;
  logic [2:0]      w_sel_arr [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_sel
    assign w_sel_arr[g] = sel[3*g +: 3];
  end

  // Scan upward from the pointer, wrapping at NREQ-1; first hit wins.
  always_comb begin
    w_gnt    = '0;
    w_any    = 1'b0;
    w_gnt_id = '0;
    w_idx    = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      w_idx = IDW'((32'(r_ptr) + k) % NREQ);
      if (!w_any && req[w_idx]) begin
        w_any        = 1'b1;
        w_gnt_id     = w_idx;
        w_gnt[w_idx] = 1'b1;
      end
    end
    if (reset) begin
      w_gnt = '0;
      w_any = 1'b0;
    end
  end

  assign w_sel = w_sel_arr[w_gnt_id];

  always_comb begin
    w_addr = '0;
    if (w_sel <= 3'd4) w_addr = AW'(1) << w_sel;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr      <= '0;
      r_rom_addr <= '0;
      r_s1_valid <= 1'b0;
      r_s1_id    <= '0;
      r_s2_valid <= 1'b0;
      r_s2_id    <= '0;
    end else begin
      if (w_any)
        r_ptr <= (w_gnt_id == IDW'(NREQ-1)) ? '0 : w_gnt_id + IDW'(1);
      r_rom_addr <= w_any ? w_addr : '0;
      r_s1_valid <= w_any;
      r_s1_id    <= w_gnt_id;
      r_s2_valid <= r_s1_valid;
      r_s2_id    <= r_s1_id;
    end
  end

  assign gnt       = w_gnt;
  assign rom_addr  = r_rom_addr;
  assign rsp_valid = r_s2_valid;
  assign rsp_id    = r_s2_id;
  // ROM output is only meaningful when a lookup is landing this cycle.
  assign rsp_data  = r_s2_valid ? rom_out : '0;
  assign rsp_err   = r_s2_valid & ~rom_effective;

endmodule

// File: doc/const_arbiter.md
Name: const_arbiter

Overview:
- Shares the single constant ROM among NREQ requesters. The ROM is one-hot addressed, has 1-cycle registered latency and a 198-bit GF(3^m) output.
- Requesters are the ALU/sequencer ports that need constants 0, 1, +, - or cubic.
- Round-robin arbitration; at most one ROM lookup issued per cycle.
- Each response is returned tagged with the requester id, two cycles after its grant.

Parameters:
NREQ, 4, number of requesters (2..8)
IDW, 2, width of requester id, = clog2(NREQ)
WIDTH, 198, constant data width
AW, 7, ROM address width

Ports:
clk  input  1  clock, all state on posedge
reset  input  1  synchronous, active-high reset
req  input  NREQ  per-requester request level
sel  input  3*NREQ  per-requester constant selector, requester i uses sel[3i+2:3i]
gnt  output  NREQ  one-hot grant, combinational, same cycle as accepted req
rom_addr  output  AW  registered one-hot address to constant ROM
rom_out  input  WIDTH  ROM data
rom_effective  input  1  ROM valid flag
rsp_valid  output  1  response valid
rsp_id  output  IDW  requester id of response
rsp_data  output  WIDTH  constant value
rsp_err  output  1  response for invalid selector

Behaviour:
- Reset (synchronous, active-high):
  - rom_addr=0, rsp_valid=0, rsp_id=0, rsp_err=0, rsp_data=0.
  - Round-robin pointer=0; both valid/id pipeline stages cleared.
  - gnt forced to 0 while reset=1.
- Arbitration (combinational):
  - Among asserted req bits, grant the first at or after pointer p, scanning upward with wrap at NREQ-1 -> 0.
  - gnt has at most one bit set; gnt=0 when req=0.
  - On any grant to i, p <= (i+1) mod NREQ at the clock edge; otherwise p holds.
- Request protocol:
  - Requester holds req and sel stable until it sees gnt.
  - sel is sampled at the edge ending the gnt cycle.
  - req still high in the cycle after gnt is a new request; it gets lowest priority because of the pointer update.
  - A requester may retract req without a grant (no side effects).
- Selector to address mapping, registered at the grant edge:
  - 0 -> 7'h01 (zero)
  - 1 -> 7'h02 (one)
  - 2 -> 7'h04 (+)
  - 3 -> 7'h08 (-)
  - 4 -> 7'h10 (cubic)
  - 5..7 -> 7'h00 (invalid)
  - No grant in a cycle -> rom_addr <= 0 next cycle.
- Pipeline (grant in cycle T):
  - rom_addr valid in T+1.
  - ROM output valid in T+2.
  - Stage1 {valid,id} at T+1, stage2 at T+2.
  - rsp_valid=1 and rsp_id=i exactly in T+2.
- Response outputs:
  - rsp_data = rom_out when rsp_valid, else 0.
  - rsp_err = rsp_valid & ~rom_effective; an invalid sel yields rsp_valid=1, rsp_err=1, rsp_data=0.
- Throughput: one grant per cycle; back-to-back grants produce back-to-back responses in order of grant; no back-pressure on the response side.
- Reset mid-operation:
  - All in-flight lookups are dropped; no rsp_valid in the 2 cycles after reset deasserts unless new grants occur.
  - ROM output during that time is ignored.
  - Requesters must re-request.
- Simultaneous events:
  - A grant and a response in the same cycle are independent.
  - reset=1 with req high: no grant, pointer stays 0.

Test Plan:
- Single request: req=4'b0010, sel1=2 at cycle 5 -> gnt=4'b0010 in cycle 5; rom_addr=7'h04 in cycle 6; rsp_valid=1, rsp_id=1, rsp_data={6'b000101,192'd0}, rsp_err=0 in cycle 7.
- All four requesting continuously from reset -> grants in order 0,1,2,3,0,1,… one per cycle; responses follow with ids 0,1,2,3 two cycles later, each carrying that requester's constant.
- Fairness:
  - req0 held high, req2 pulsed -> req2 granted within 2 cycles.
  - Pointer after grant to 3 wraps to 0.
- Invalid selector: sel0=6 granted -> rom_addr=0 in cycle T+1; cycle T+2: rsp_valid=1, rsp_err=1, rsp_data=0.
- Mapping sweep: sel 0..4 from requester 3 -> rsp_data = 0, 1, {000101,0}, {001001,0}, {010101,0} respectively, rsp_id=3.
- Reset mid-flight: grants in cycles T and T+1, reset=1 in T+1 -> no gnt in T+1; no rsp_valid in T+2..T+3; rom_addr=0 and pointer=0 after reset.
